// File: rtl/risc_prog_loader.sv
// Streaming program loader: packs a byte stream little-endian into instruction words, writes
// them to consecutive addresses, and holds the core halted until the final word has landed.
module risc_prog_loader #(
  parameter int INSTR_WIDTH = 16,
  parameter int ADDR_WIDTH  = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_start,
  input  logic                   in_valid,
  input  logic [7:0]             in_byte,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [INSTR_WIDTH-1:0] mem_wdata,
  output logic                   cpu_run,
  output logic [ADDR_WIDTH:0]    words_loaded,
  output logic [7:0]             checksum,
  output logic                   overflow
);

  localparam int BYTES = INSTR_WIDTH / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0]      LAST_LANE = CNT_W'(BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = '1;

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, RUN} state_t;

  state_t                 state_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [INSTR_WIDTH-1:0] asm_q;
  logic [INSTR_WIDTH-1:0] asm_d;
  logic                   pend_q;
  logic                   in_ready_q;
  logic                   mem_we_q;
  logic [ADDR_WIDTH-1:0]  mem_addr_q;
  logic [INSTR_WIDTH-1:0] mem_wdata_q;
  logic                   cpu_run_q;
  logic [ADDR_WIDTH:0]    words_q;
  logic [7:0]             csum_q;
  logic                   ovf_q;
  logic                   accept;

  assign accept = in_valid && in_ready_q;

  always_comb begin
    asm_d = asm_q;
    asm_d[{cnt_q, 3'b000} +: 8] = in_byte;
  end

  // in_ready is only ever set on entry to LOAD, so it never depends on in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      asm_q       <= '0;
      pend_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_run_q   <= 1'b0;
      words_q     <= '0;
      csum_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      if (load_start) begin
        state_q    <= LOAD;
        addr_q     <= '0;
        cnt_q      <= '0;
        asm_q      <= '0;
        pend_q     <= 1'b0;
        in_ready_q <= 1'b1;
        cpu_run_q  <= 1'b0;
        words_q    <= '0;
        csum_q     <= '0;
        ovf_q      <= 1'b0;
      end else begin
        case (state_q)
          LOAD: begin
            if (accept) begin
              csum_q <= csum_q + in_byte;
              if (in_last || (cnt_q == LAST_LANE)) begin
                state_q     <= WRITE;
                in_ready_q  <= 1'b0;
                mem_we_q    <= 1'b1;
                mem_addr_q  <= addr_q;
                mem_wdata_q <= asm_d;
                pend_q      <= in_last;
                asm_q       <= '0;
                cnt_q       <= '0;
              end else begin
                asm_q <= asm_d;
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
          WRITE: begin
            words_q <= words_q + (ADDR_WIDTH+1)'(1);
            if (pend_q) begin
              state_q   <= RUN;
              cpu_run_q <= 1'b1;
            end else if (addr_q == ADDR_MAX) begin
              state_q <= IDLE;
              ovf_q   <= 1'b1;
            end else begin
              state_q    <= LOAD;
              addr_q     <= addr_q + ADDR_WIDTH'(1);
              in_ready_q <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign in_ready     = in_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign cpu_run      = cpu_run_q;
  assign words_loaded = words_q;
  assign checksum     = csum_q;
  assign overflow     = ovf_q;

endmodule
